// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer for the 7-output two-input gate bank; checks all four vectors per run.
// Run takes 4*SETTLE_CYCLES cycles from accepted start to done; start is ignored while busy.
module gate_selftest_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       man_a,
   input  logic       man_b,
   output logic       gate_a,
   output logic       gate_b,
   input  logic [6:0] gate_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] err_mask,
   output logic [2:0] err_count
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic       gate_a_q, gate_a_d;
   logic       gate_b_q, gate_b_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [6:0] err_mask_q, err_mask_d;
   logic [2:0] err_count_q, err_count_d;

   logic [6:0] exp_y;
   logic [6:0] mism;
   logic [2:0] count_chk;
   logic [1:0] idx_nxt;

   // Expected bank response for the operands currently driven out.
   assign exp_y = {~(gate_a_q ^ gate_b_q), gate_a_q ^ gate_b_q, ~(gate_a_q | gate_b_q),
                   ~(gate_a_q & gate_b_q), gate_a_q | gate_b_q, gate_a_q & gate_b_q, ~gate_a_q};
   assign mism      = gate_y ^ exp_y;
   assign count_chk = err_count_q + {2'b00, |mism};
   assign idx_nxt   = idx_q + 2'd1;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      gate_a_d    = gate_a_q;
      gate_b_d    = gate_b_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      err_mask_d  = err_mask_q;
      err_count_d = err_count_q;
      case (state_q)
         IDLE: begin
            gate_a_d = man_a;
            gate_b_d = man_b;
            if (start) begin
               state_d     = RUN;
               busy_d      = 1'b1;
               pass_d      = 1'b0;
               err_mask_d  = '0;
               err_count_d = '0;
               idx_d       = 2'd0;
               gate_a_d    = 1'b0;
               gate_b_d    = 1'b0;
               cnt_d       = RELOAD;
            end
         end
         RUN: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               err_mask_d  = err_mask_q | mism;
               err_count_d = count_chk;
               if (idx_q != 2'd3) begin
                  idx_d    = idx_nxt;
                  gate_a_d = idx_nxt[1];
                  gate_b_d = idx_nxt[0];
                  cnt_d    = RELOAD;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (count_chk == 3'd0);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= 2'd0;
         cnt_q       <= 8'd0;
         gate_a_q    <= 1'b0;
         gate_b_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_mask_q  <= 7'd0;
         err_count_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         gate_a_q    <= gate_a_d;
         gate_b_q    <= gate_b_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_mask_q  <= err_mask_d;
         err_count_q <= err_count_d;
      end
   end

   assign gate_a    = gate_a_q;
   assign gate_b    = gate_b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_mask  = err_mask_q;
   assign err_count = err_count_q;

endmodule
